// File: rtl/ram_arb_pkg.sv
// Shared types and default constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT_DEF = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        DONE
    } arb_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; the "last granted" pointer lives in the caller.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic       valid,
    output req_id_t    winner
);

    // On a tie the requester that was not granted last takes its turn.
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer putting two req/ack clients onto one synchronous RAM.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_e        state_q, state_d;
    req_id_t           id_q, id_d;
    req_id_t           last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata_q;

    logic              pickValid;
    req_id_t           pickId;
    logic              selWe;

    rr_pick2 u_pick (
        .req    ({r1_req, r0_req}),
        .last   (last_q),
        .valid  (pickValid),
        .winner (pickId)
    );

    assign selWe = pickId ? r1_we : r0_we;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    id_d    = pickId;
                    last_d  = pickId;
                    we_d    = selWe;
                    addr_d  = pickId ? r1_addr : r0_addr;
                    wdata_d = pickId ? r1_wdata : r0_wdata;
                    if (selWe) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                        cnt_d   = CNT_W'(RD_LAT);
                    end
                end
            end
            WR:   state_d = DONE;
            // The counter is loaded with RD_LAT at grant, so RD lasts exactly RD_LAT cycles.
            RD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = CAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAP:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ack0_q  <= (state_d == DONE) && (id_q == 1'b0);
            ack1_q  <= (state_d == DONE) && (id_q == 1'b1);
            if (state_q == CAP) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    // Strobes come only from registered state and latched fields; bus is zero when idle.
    assign ram_cs    = (state_q == WR) || (state_q == RD);
    assign ram_we    = (state_q == WR);
    assign ram_re    = (state_q == RD);
    assign ram_addr  = ram_cs ? addr_q : '0;
    assign ram_wdata = ram_we ? wdata_q : '0;
    assign r0_ack    = ack0_q;
    assign r1_ack    = ack1_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: default build (RD_LAT=2) plus an RD_LAT=1 build.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;

    logic        a0Req, a0We, a1Req, a1We;
    logic [15:0] a0Addr, a1Addr;
    logic [7:0]  a0Wdata, a1Wdata;
    logic        a0Ack, a1Ack;
    logic [7:0]  aRdata, aRamRdata;
    logic        aCs, aWe, aRe;
    logic [15:0] aAddr;
    logic [7:0]  aWdata;

    logic        b0Req, b0We, b1Req, b1We;
    logic [15:0] b0Addr, b1Addr;
    logic [7:0]  b0Wdata, b1Wdata;
    logic        b0Ack, b1Ack;
    logic [7:0]  bRdata, bRamRdata;
    logic        bCs, bWe, bRe;
    logic [15:0] bAddr;
    logic [7:0]  bWdata;

    int passCount;
    int checkCount;

    logic [7:0] memA [0:255];
    logic [7:0] aS1, aS2, bS1;

    ram_arbiter dutA (
        .clk(clk), .rst_n(rst_n),
        .r0_req(a0Req), .r0_we(a0We), .r0_addr(a0Addr), .r0_wdata(a0Wdata),
        .r1_req(a1Req), .r1_we(a1We), .r1_addr(a1Addr), .r1_wdata(a1Wdata),
        .r0_ack(a0Ack), .r1_ack(a1Ack), .rdata(aRdata),
        .ram_cs(aCs), .ram_we(aWe), .ram_re(aRe),
        .ram_addr(aAddr), .ram_wdata(aWdata), .ram_rdata(aRamRdata)
    );

    ram_arbiter #(.RD_LAT(1)) dutB (
        .clk(clk), .rst_n(rst_n),
        .r0_req(b0Req), .r0_we(b0We), .r0_addr(b0Addr), .r0_wdata(b0Wdata),
        .r1_req(b1Req), .r1_we(b1We), .r1_addr(b1Addr), .r1_wdata(b1Wdata),
        .r0_ack(b0Ack), .r1_ack(b1Ack), .rdata(bRdata),
        .ram_cs(bCs), .ram_we(bWe), .ram_re(bRe),
        .ram_addr(bAddr), .ram_wdata(bWdata), .ram_rdata(bRamRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM with a two-stage read pipeline for the default build.
    always @(posedge clk) begin
        if (aCs && aWe) memA[aAddr[7:0]] <= aWdata;
        if (aCs && aRe) aS1 <= memA[aAddr[7:0]];
        aS2 <= aS1;
    end
    assign aRamRdata = aS2;

    // Single-stage read RAM for the RD_LAT=1 build, address 3 preloaded with 0x5C.
    always @(posedge clk) begin
        if (bCs && bRe) bS1 <= (bAddr == 16'h0003) ? 8'h5C : 8'h00;
    end
    assign bRamRdata = bS1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int who, input logic req, input logic we,
                                 input logic [15:0] addr, input logic [7:0] wdata);
        case (who)
            0: begin a0Req = req; a0We = we; a0Addr = addr; a0Wdata = wdata; end
            1: begin a1Req = req; a1We = we; a1Addr = addr; a1Wdata = wdata; end
            default: begin b0Req = req; b0We = we; b0Addr = addr; b0Wdata = wdata; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 8'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 8'h0);
        applyStimulus(2, 1'b0, 1'b0, 16'h0, 8'h0);
        b1Req = 1'b0; b1We = 1'b0; b1Addr = 16'h0; b1Wdata = 8'h0;

        tick(); tick();
        checkOutput("rst_strobes", {29'd0, aCs, aWe, aRe}, 32'd0);
        checkOutput("rst_bus", {8'd0, aAddr, aWdata}, 32'd0);
        checkOutput("rst_acks_rdata", {22'd0, a0Ack, a1Ack, aRdata}, 32'd0);
        checkOutput("rst_b_outputs", {bCs, bWe, bRe, b0Ack, b1Ack, bAddr, bRdata}, 32'd0);

        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 16'h0010, 8'hA5);
        tick();
        checkOutput("wr_c1_strobes", {29'd0, aCs, aWe, aRe}, 32'b110);
        checkOutput("wr_c1_bus", {8'd0, aAddr, aWdata}, {8'd0, 16'h0010, 8'hA5});
        checkOutput("wr_c1_ack", {30'd0, a0Ack, a1Ack}, 32'd0);
        tick();
        checkOutput("wr_c2_ack", {30'd0, a0Ack, a1Ack}, 32'b10);
        checkOutput("wr_c2_strobes", {5'd0, aCs, aWe, aRe, aAddr, aWdata}, 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        checkOutput("wr_c3_ack", {30'd0, a0Ack, a1Ack}, 32'd0);

        applyStimulus(1, 1'b1, 1'b0, 16'h0010, 8'h00);
        tick();
        checkOutput("rd_c1", {12'd0, aCs, aWe, aRe, aAddr}, {12'd0, 3'b101, 16'h0010});
        tick();
        checkOutput("rd_c2", {29'd0, aCs, aWe, aRe}, 32'b101);
        tick();
        checkOutput("rd_c3_cap", {27'd0, aCs, aRe, a0Ack, a1Ack}, 32'd0);
        tick();
        checkOutput("rd_c4_ack", {30'd0, a0Ack, a1Ack}, 32'b01);
        checkOutput("rd_c4_rdata", {24'd0, aRdata}, 32'hA5);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();

        applyStimulus(0, 1'b1, 1'b1, 16'h0020, 8'h11);
        applyStimulus(1, 1'b1, 1'b1, 16'h0021, 8'h22);
        for (int k = 1; k <= 11; k++) begin
            tick();
            checkOutput($sformatf("rr_ack_k%0d", k), {30'd0, a1Ack, a0Ack},
                        {30'd0, (k == 5 || k == 11), (k == 2 || k == 8)});
            if (k % 3 == 1) begin
                checkOutput($sformatf("rr_wr_k%0d", k), {13'd0, aCs, aWe, aRe, aAddr},
                            {13'd0, 3'b110, ((k == 1 || k == 7) ? 16'h0020 : 16'h0021)});
            end else begin
                checkOutput($sformatf("rr_idle_k%0d", k), {29'd0, aCs, aWe, aRe}, 32'd0);
            end
        end
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 8'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();

        applyStimulus(0, 1'b1, 1'b1, 16'h0030, 8'h77);
        tick();
        a0Addr = 16'h0031;
        a0Wdata = 8'h88;
        #1;
        checkOutput("latch_bus", {8'd0, aAddr, aWdata}, {8'd0, 16'h0030, 8'h77});
        tick();
        checkOutput("latch_ack", {30'd0, a0Ack, a1Ack}, 32'b10);
        checkOutput("latch_mem", {24'd0, memA[8'h30]}, 32'h77);
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();

        applyStimulus(1, 1'b1, 1'b0, 16'h0020, 8'h00);
        tick();
        checkOutput("rst_mid_rd_pre", {29'd0, aCs, aWe, aRe}, 32'b101);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_strobes", {5'd0, aCs, aWe, aRe, aAddr, aWdata}, 32'd0);
        checkOutput("rst_mid_ack_rdata", {22'd0, a0Ack, a1Ack, aRdata}, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 8'h00);
        tick();
        tick();
        checkOutput("rst_mid_no_ack", {29'd0, a0Ack, a1Ack, aRe}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 16'h0020, 8'h00);
        tick();
        checkOutput("post_rst_rd_c1", {29'd0, aCs, aWe, aRe}, 32'b101);
        tick(); tick(); tick();
        checkOutput("post_rst_rd_ack", {22'd0, a0Ack, a1Ack, aRdata}, {22'd0, 2'b01, 8'h11});
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 8'h00);
        tick();

        applyStimulus(2, 1'b1, 1'b0, 16'h0003, 8'h00);
        tick();
        checkOutput("lat1_c1", {12'd0, bCs, bWe, bRe, bAddr}, {12'd0, 3'b101, 16'h0003});
        tick();
        checkOutput("lat1_c2", {27'd0, bCs, bRe, b0Ack, b1Ack}, 32'd0);
        tick();
        checkOutput("lat1_c3_ack", {22'd0, b0Ack, b1Ack, bRdata}, {22'd0, 2'b10, 8'h5C});
        applyStimulus(2, 1'b0, 1'b0, 16'h0, 8'h00);
        tick();
        checkOutput("lat1_c4_idle", {22'd0, b0Ack, b1Ack, bRdata}, {22'd0, 2'b00, 8'h5C});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
